if_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register of the pipelined MIPS core; directly upstream of the control unit.
- Owns the PC and runs a req/ack handshake to instruction memory.
- Presents the instruction and PC+4 to decode; op = if_id_instr[31:26], funct = if_id_instr[5:0].
- Honours hazard-unit stalls and branch redirects; a flushed slot carries the NOP encoding (op 6'b111111).

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/if_id_reg.sv | 49 ++++
 rtl/if_stage.sv | 182 ++++++++++++++++++
 tb/tb_if_stage.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared across the pipelined MIPS core.
//   - if_state_t : fetch-stage sequencer states
//   - RESET_PC, NOP_INSTR, PC_STEP : fetch defaults
//   - OP_* : primary opcodes, instr[31:26], decoded by the control unit
package cpu_pkg;

    typedef enum logic [1:0] {
        START = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } if_state_t;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'hFC00_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    localparam logic [5:0] OP_NOP   = 6'b111111;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // Clear the byte-offset bits so a fetch address is always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: pipeline stage register holding {instr, pc_plus4, valid}.
// Flush has priority over load; with neither asserted the contents hold.
// Ports:
//   clk, reset_n         clock, async active-low reset
//   i_load               capture i_instr / i_pc_plus4 and mark valid
//   i_flush              replace contents with the bubble word, valid=0
//   i_instr, i_pc_plus4  incoming instruction and its PC+4
//   o_instr, o_pc_plus4, o_valid  registered stage contents
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] FLUSH_INSTR = NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_load,
    input  logic        i_flush,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc_plus4,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc_plus4,
    output logic        o_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pc_plus4;
    logic        r_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_instr    <= FLUSH_INSTR;
            r_pc_plus4 <= 32'h0;
            r_valid    <= 1'b0;
        end else if (i_flush) begin
            r_instr    <= FLUSH_INSTR;
            r_pc_plus4 <= 32'h0;
            r_valid    <= 1'b0;
        end else if (i_load) begin
            r_instr    <= i_instr;
            r_pc_plus4 <= i_pc_plus4;
            r_valid    <= 1'b1;
        end
    end

    assign o_instr    = r_instr;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_valid    = r_valid;

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch plus IF/ID register.
// Owns the PC, runs a req/ack handshake with instruction memory, honours
// hazard stalls and branch redirects, and feeds decode.
// Optional build macro IF_PERF_CNT_EN adds perf_fetched / perf_stall_cycles.
// Ports:
//   clk, reset_n                   clock, async active-low reset
//   stall                          hold IF/ID and PC
//   branch_taken, branch_target    one-cycle redirect request and address
//   imem_req, imem_addr            registered fetch request / address
//   imem_ack, imem_rdata           data-valid pulse and instruction word
//   if_id_instr, if_id_pc_plus4, if_id_valid   decode-stage inputs
//   perf_fetched, perf_stall_cycles (IF_PERF_CNT_EN only) saturating counters
//
// state | meaning
// START | after reset, no request yet
// FETCH | request outstanding at imem_addr = pc
// HOLD  | word buffered during a stall, no request
// DRAIN | redirect seen mid-request; wait for the ack, drop it, then jump
module if_stage #(
    parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR,
    parameter logic [31:0] PC_STEP   = cpu_pkg::PC_STEP
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid
`ifdef IF_PERF_CNT_EN
   ,output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall_cycles
`endif
);

    import cpu_pkg::*;

    if_state_t   r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_buf, w_buf_nxt;
    logic [31:0] r_target, w_target_nxt;
    logic        r_req;
    logic        w_ack;
    logic        w_load;
    logic        w_flush;
    logic [31:0] w_load_instr;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_tgt;

    // An ack only counts while a request is actually outstanding.
    assign w_ack      = imem_ack & r_req;
    assign w_pc_plus4 = r_pc + PC_STEP;
    assign w_tgt      = word_align(branch_target);

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_buf_nxt    = r_buf;
        w_target_nxt = r_target;
        w_load       = 1'b0;
        w_flush      = 1'b0;
        w_load_instr = imem_rdata;
        case (r_state)
            START: begin
                w_state_nxt = FETCH;
                if (branch_taken) begin
                    w_flush  = 1'b1;
                    w_pc_nxt = w_tgt;
                end
            end
            FETCH: begin
                if (branch_taken) begin
                    w_flush = 1'b1;
                    if (w_ack) begin
                        w_pc_nxt = w_tgt;
                    end else begin
                        // Request is in flight: address must not move.
                        w_target_nxt = w_tgt;
                        w_state_nxt  = DRAIN;
                    end
                end else if (w_ack && !stall) begin
                    w_load   = 1'b1;
                    w_pc_nxt = w_pc_plus4;
                end else if (w_ack) begin
                    w_buf_nxt   = imem_rdata;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    w_flush     = 1'b1;
                    w_pc_nxt    = w_tgt;
                    w_state_nxt = FETCH;
                end else if (!stall) begin
                    w_load       = 1'b1;
                    w_load_instr = r_buf;
                    w_pc_nxt     = w_pc_plus4;
                    w_state_nxt  = FETCH;
                end
            end
            DRAIN: begin
                if (branch_taken) begin
                    w_flush      = 1'b1;
                    w_target_nxt = w_tgt;
                end
                if (w_ack) begin
                    // Latest redirect wins, including one arriving with the ack.
                    w_pc_nxt    = branch_taken ? w_tgt : r_target;
                    w_state_nxt = FETCH;
                end
            end
            default: w_state_nxt = START;
        endcase
        if (w_flush) begin
            w_buf_nxt = NOP_INSTR;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= START;
            r_pc     <= RESET_PC;
            r_buf    <= NOP_INSTR;
            r_target <= RESET_PC;
            r_req    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_buf    <= w_buf_nxt;
            r_target <= w_target_nxt;
            r_req    <= (w_state_nxt == FETCH) || (w_state_nxt == DRAIN);
        end
    end

    // The PC only advances on an ack or from HOLD/START, so driving the
    // address straight from it keeps it stable while a request is pending.
    assign imem_req  = r_req;
    assign imem_addr = r_pc;

    if_id_reg #(
        .FLUSH_INSTR(NOP_INSTR)
    ) u_if_id_reg (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_load    (w_load),
        .i_flush   (w_flush),
        .i_instr   (w_load_instr),
        .i_pc_plus4(w_pc_plus4),
        .o_instr   (if_id_instr),
        .o_pc_plus4(if_id_pc_plus4),
        .o_valid   (if_id_valid)
    );

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_perf_fetched <= 32'h0;
            r_perf_stall   <= 32'h0;
        end else begin
            if (w_load && (r_perf_fetched != 32'hFFFF_FFFF)) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (stall && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetched      = r_perf_fetched;
    assign perf_stall_cycles = r_perf_stall;
`endif

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    localparam logic [31:0] NOP = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall_cycles;
`endif

    int vectors = 0;
    int miscompares = 0;

    if_stage dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .if_id_instr   (if_id_instr),
        .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_valid   (if_id_valid)
`ifdef IF_PERF_CNT_EN
       ,.perf_fetched     (perf_fetched),
        .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    // Contents of memory at a word address, as the bench's memory returns it.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_n = 1'b1;
        #1;
        reset_n       = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        imem_ack      = 1'b0;
        imem_rdata    = 32'h0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        reset_n = 1'b1;
        #1;
        reset_n = 1'b0;
        #2;
        vectors++;
        if ({imem_req, imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid} !==
            {1'b0, 32'h0, NOP, 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state got req=%b addr=%h instr=%h pc4=%h v=%b want 0/0/%h/0/0",
                     imem_req, imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid, NOP);
        end
`ifdef IF_PERF_CNT_EN
        vectors++;
        if ({perf_fetched, perf_stall_cycles} !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_perf got %h/%h want 0/0", perf_fetched, perf_stall_cycles);
        end
`endif
        do_reset();
    endtask

    task automatic test_zero_wait;
        do_reset();
        tick();
        vectors++;
        if ({imem_req, imem_addr, if_id_valid} !== {1'b1, 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL zw_first_req got req=%b addr=%h v=%b want 1/0/0", imem_req, imem_addr, if_id_valid);
        end
        for (int i = 0; i < 4; i++) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
            tick();
            vectors++;
            if ({imem_addr, if_id_pc_plus4, if_id_valid, if_id_instr} !==
                {32'(4 * (i + 1)), 32'(4 * (i + 1)), 1'b1, mem_word(32'(4 * i))}) begin
                miscompares++;
                $display("FAIL zw_stream[%0d] got addr=%h pc4=%h v=%b instr=%h want %h/%h/1/%h", i,
                         imem_addr, if_id_pc_plus4, if_id_valid, if_id_instr,
                         32'(4 * (i + 1)), 32'(4 * (i + 1)), mem_word(32'(4 * i)));
            end
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_stall_latency;
        do_reset();
        tick();
        stall    = 1'b1;
        imem_ack = 1'b0;
        tick();
        vectors++;
        if ({imem_req, imem_addr, if_id_valid} !== {1'b1, 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL stall_wait got req=%b addr=%h v=%b want 1/0/0", imem_req, imem_addr, if_id_valid);
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_ABCD;
        tick();
        vectors++;
        if ({imem_req, if_id_valid, if_id_instr} !== {1'b0, 1'b0, NOP}) begin
            miscompares++;
            $display("FAIL stall_hold_entry got req=%b v=%b instr=%h want 0/0/%h", imem_req, if_id_valid, if_id_instr, NOP);
        end
        // Spurious ack while no request is outstanding must be ignored.
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        vectors++;
        if ({imem_req, if_id_valid, if_id_instr} !== {1'b0, 1'b0, NOP}) begin
            miscompares++;
            $display("FAIL stall_hold_keep got req=%b v=%b instr=%h want 0/0/%h", imem_req, if_id_valid, if_id_instr, NOP);
        end
        stall    = 1'b0;
        imem_ack = 1'b0;
        tick();
        vectors++;
        if ({if_id_instr, if_id_pc_plus4, if_id_valid, imem_req, imem_addr} !==
            {32'h1234_ABCD, 32'h4, 1'b1, 1'b1, 32'h4}) begin
            miscompares++;
            $display("FAIL stall_release got instr=%h pc4=%h v=%b req=%b addr=%h want 1234abcd/4/1/1/4",
                     if_id_instr, if_id_pc_plus4, if_id_valid, imem_req, imem_addr);
        end
        stall = 1'b1;
        tick();
        vectors++;
        if ({if_id_instr, if_id_pc_plus4, if_id_valid} !== {32'h1234_ABCD, 32'h4, 1'b1}) begin
            miscompares++;
            $display("FAIL stall_keep_valid got instr=%h pc4=%h v=%b want 1234abcd/4/1",
                     if_id_instr, if_id_pc_plus4, if_id_valid);
        end
        stall = 1'b0;
    endtask

    task automatic test_branch_drain;
        do_reset();
        tick();
        for (int i = 0; i < 4; i++) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
            tick();
        end
        imem_ack      = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        tick();
        vectors++;
        if ({if_id_valid, if_id_instr, if_id_pc_plus4, imem_req, imem_addr} !==
            {1'b0, NOP, 32'h0, 1'b1, 32'h10}) begin
            miscompares++;
            $display("FAIL drain_flush got v=%b instr=%h pc4=%h req=%b addr=%h want 0/%h/0/1/10",
                     if_id_valid, if_id_instr, if_id_pc_plus4, imem_req, imem_addr, NOP);
        end
        branch_taken = 1'b0;
        stall        = 1'b1;
        tick();
        vectors++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h10}) begin
            miscompares++;
            $display("FAIL drain_hold_addr got req=%b addr=%h want 1/10", imem_req, imem_addr);
        end
        imem_ack   = 1'b1;
        imem_rdata = mem_word(32'h10);
        tick();
        vectors++;
        if ({if_id_valid, if_id_instr, imem_req, imem_addr} !== {1'b0, NOP, 1'b1, 32'h40}) begin
            miscompares++;
            $display("FAIL drain_done got v=%b instr=%h req=%b addr=%h want 0/%h/1/40",
                     if_id_valid, if_id_instr, imem_req, imem_addr, NOP);
        end
        stall      = 1'b0;
        imem_rdata = mem_word(32'h40);
        tick();
        vectors++;
        if ({if_id_instr, if_id_pc_plus4, if_id_valid} !== {mem_word(32'h40), 32'h44, 1'b1}) begin
            miscompares++;
            $display("FAIL drain_target_fetch got instr=%h pc4=%h v=%b want %h/44/1",
                     if_id_instr, if_id_pc_plus4, if_id_valid, mem_word(32'h40));
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_branch_ack_stall;
        imem_ack      = 1'b1;
        imem_rdata    = 32'hBAD0_BAD0;
        stall         = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h83;
        tick();
        vectors++;
        if ({if_id_valid, if_id_instr, imem_req, imem_addr} !== {1'b0, NOP, 1'b1, 32'h80}) begin
            miscompares++;
            $display("FAIL redirect_priority got v=%b instr=%h req=%b addr=%h want 0/%h/1/80",
                     if_id_valid, if_id_instr, imem_req, imem_addr, NOP);
        end
        branch_taken = 1'b0;
        stall        = 1'b0;
        imem_ack     = 1'b0;
    endtask

    task automatic test_wrap;
        imem_ack      = 1'b1;
        imem_rdata    = mem_word(imem_addr);
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        tick();
        vectors++;
        if (imem_addr !== 32'hFFFF_FFFC) begin
            miscompares++;
            $display("FAIL wrap_redirect got addr=%h want fffffffc", imem_addr);
        end
        branch_taken = 1'b0;
        imem_rdata   = mem_word(32'hFFFF_FFFC);
        tick();
        vectors++;
        if ({if_id_pc_plus4, if_id_valid, imem_addr, if_id_instr} !==
            {32'h0, 1'b1, 32'h0, mem_word(32'hFFFF_FFFC)}) begin
            miscompares++;
            $display("FAIL wrap_pc got pc4=%h v=%b addr=%h instr=%h want 0/1/0/%h",
                     if_id_pc_plus4, if_id_valid, imem_addr, if_id_instr, mem_word(32'hFFFF_FFFC));
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_reset_mid_wait;
        imem_ack = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({imem_req, imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid} !==
            {1'b0, 32'h0, NOP, 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL rst_async got req=%b addr=%h instr=%h pc4=%h v=%b want 0/0/%h/0/0",
                     imem_req, imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid, NOP);
        end
`ifdef IF_PERF_CNT_EN
        vectors++;
        if ({perf_fetched, perf_stall_cycles} !== 64'h0) begin
            miscompares++;
            $display("FAIL rst_perf got %h/%h want 0/0", perf_fetched, perf_stall_cycles);
        end
`endif
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_0001;
        tick();
        vectors++;
        if ({if_id_instr, if_id_valid, imem_req} !== {NOP, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL rst_late_ack got instr=%h v=%b req=%b want %h/0/0", if_id_instr, if_id_valid, imem_req, NOP);
        end
        reset_n = 1'b1;
        tick();
        vectors++;
        if ({if_id_valid, if_id_instr, imem_req, imem_addr} !== {1'b0, NOP, 1'b1, 32'h0}) begin
            miscompares++;
            $display("FAIL rst_restart got v=%b instr=%h req=%b addr=%h want 0/%h/1/0",
                     if_id_valid, if_id_instr, imem_req, imem_addr, NOP);
        end
        imem_ack = 1'b0;
    endtask

    // Random stall/redirect/latency traffic. The reference is the program
    // order of delivered words: each new valid IF/ID entry must be the word
    // at the next expected address, which restarts at the aligned target of
    // every redirect.
    task automatic test_random;
        logic [31:0] exp_addr, a_tgt, a_addr, p_instr, p_pc4;
        logic        a_stall, a_br, a_ack, a_req, p_valid;
        int          wcnt, delivered, stall_cnt;
        do_reset();
        exp_addr  = 32'h0;
        wcnt      = 0;
        delivered = 0;
        stall_cnt = 0;
        p_instr   = if_id_instr;
        p_pc4     = if_id_pc_plus4;
        p_valid   = if_id_valid;
        for (int n = 0; n < 3000; n++) begin
            stall         = ($urandom_range(0, 99) < 30);
            branch_taken  = ($urandom_range(0, 99) < 6);
            branch_target = 32'($urandom_range(0, 1023));
            if (imem_req) begin
                if (wcnt == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    wcnt       = int'($urandom_range(0, 2));
                end else begin
                    wcnt--;
                    imem_ack   = 1'b0;
                    imem_rdata = $urandom;
                end
            end else begin
                imem_ack   = ($urandom_range(0, 9) == 0);
                imem_rdata = 32'hDEAD_0000 | 32'($urandom_range(0, 65535));
            end
            a_stall = stall;
            a_br    = branch_taken;
            a_tgt   = branch_target;
            a_ack   = imem_ack;
            a_req   = imem_req;
            a_addr  = imem_addr;
            if (stall) stall_cnt++;
            tick();
            if (a_req && !a_ack) begin
                vectors++;
                if ({imem_req, imem_addr} !== {1'b1, a_addr}) begin
                    miscompares++;
                    $display("FAIL rnd_addr_stable cyc=%0d got req=%b addr=%h want 1/%h", n, imem_req, imem_addr, a_addr);
                end
            end
            if (a_br) begin
                vectors++;
                if ({if_id_valid, if_id_instr, if_id_pc_plus4} !== {1'b0, NOP, 32'h0}) begin
                    miscompares++;
                    $display("FAIL rnd_redirect_bubble cyc=%0d got v=%b instr=%h pc4=%h", n, if_id_valid, if_id_instr, if_id_pc_plus4);
                end
                exp_addr = a_tgt & ~32'h3;
            end else if (!a_stall && if_id_valid === 1'b1 && (!p_valid || if_id_pc_plus4 !== p_pc4)) begin
                vectors++;
                if ({if_id_instr, if_id_pc_plus4} !== {mem_word(exp_addr), exp_addr + 32'd4}) begin
                    miscompares++;
                    $display("FAIL rnd_delivery cyc=%0d got instr=%h pc4=%h want %h/%h", n,
                             if_id_instr, if_id_pc_plus4, mem_word(exp_addr), exp_addr + 32'd4);
                end
                exp_addr  = exp_addr + 32'd4;
                delivered++;
            end else begin
                vectors++;
                if ({if_id_instr, if_id_pc_plus4, if_id_valid} !== {p_instr, p_pc4, p_valid}) begin
                    miscompares++;
                    $display("FAIL rnd_hold cyc=%0d stall=%b got instr=%h pc4=%h v=%b want %h/%h/%b", n, a_stall,
                             if_id_instr, if_id_pc_plus4, if_id_valid, p_instr, p_pc4, p_valid);
                end
            end
            p_instr = if_id_instr;
            p_pc4   = if_id_pc_plus4;
            p_valid = if_id_valid;
        end
        stall        = 1'b0;
        branch_taken = 1'b0;
        imem_ack     = 1'b0;
        vectors++;
        if (delivered < 100) begin
            miscompares++;
            $display("FAIL rnd_progress got %0d deliveries want >= 100", delivered);
        end
`ifdef IF_PERF_CNT_EN
        vectors++;
        if ({perf_fetched, perf_stall_cycles} !== {32'(delivered), 32'(stall_cnt)}) begin
            miscompares++;
            $display("FAIL rnd_perf got %0d/%0d want %0d/%0d", perf_fetched, perf_stall_cycles, delivered, stall_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stall_latency();
        test_branch_drain();
        test_branch_ack_stall();
        test_wrap();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
